stg_csr_bank: RTL and testbench

//   Parametrised CSR bank used behind the EX stage for CSR instructions.

---
 rtl/stg_csr_bank.sv | 163 ++++++++++++++++
 tb/tb_stg_csr_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stg_csr_bank.sv
// ---------------------------------------------------------------------------
// stg_csr_bank
//   CSR bank that sits behind the EX stage and feeds the WB result mux.
//   Supports four atomic ops on NUM_CSR registers of DATA_W bits:
//     RD  (00) : read only
//     WR  (01) : csr = wdata
//     SET (10) : csr = csr | wdata
//     CLR (11) : csr = csr & ~wdata
//   Every accepted op returns the CSR value from before the op, one cycle
//   later. Out-of-range indices and modifies of read-only CSRs are rejected
//   with ow_err and leave the bank untouched.
//
//   Optional feature, enabled by defining the macro CSR_CYCLE_EN:
//     CSR NUM_CSR-2 / NUM_CSR-1 become the low / high halves of a free-running
//     2*DATA_W-bit cycle counter (read-only). Reading the low half latches
//     the high half into a shadow, and reading the high half returns that
//     shadow, so LO-then-HI gives a coherent value. Without the macro both
//     indices are ordinary CSRs governed by RO_MASK.
//
// Ports
//   iw_clk    in   1       clock
//   iw_rst    in   1       synchronous, active-high reset
//   iw_stall  in   1       pipeline stall: nothing accepted, outputs hold
//   iw_flush  in   1       cancel this cycle's request (wins over stall)
//   iw_valid  in   1       request valid
//   iw_op     in   2       op code (RD/WR/SET/CLR)
//   iw_idx    in   IDX_W   CSR index
//   iw_wdata  in   DATA_W  write data / bit mask
//   ow_valid  out  1       response valid, one cycle per accepted request
//   ow_rdata  out  DATA_W  CSR value before the op (0 when out of range)
//   ow_err    out  1       out-of-range index or modify of read-only CSR
// ---------------------------------------------------------------------------
module stg_csr_bank #(
    parameter int                 DATA_W  = 24,
    parameter int                 NUM_CSR = 8,
    parameter int                 IDX_W   = 4,
    parameter logic [NUM_CSR-1:0] RO_MASK = '0
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_stall,
    input  logic              iw_flush,
    input  logic              iw_valid,
    input  logic [1:0]        iw_op,
    input  logic [IDX_W-1:0]  iw_idx,
    input  logic [DATA_W-1:0] iw_wdata,
    output logic              ow_valid,
    output logic [DATA_W-1:0] ow_rdata,
    output logic              ow_err
);

    localparam int SEL_W = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
    localparam logic [IDX_W:0] NUM_CSR_V = NUM_CSR[IDX_W:0];

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_SET = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    op_e               op;
    logic [SEL_W-1:0]  sel;
    logic              in_range;
    logic              accept;
    logic              is_mod;
    logic              ro;
    logic              wr_en;
    logic              err_nxt;
    logic [DATA_W-1:0] old_val;
    logic [DATA_W-1:0] new_val;
    logic [DATA_W-1:0] rdata_nxt;

    logic [DATA_W-1:0] csr_q [NUM_CSR];

    assign op       = op_e'(iw_op);
    assign sel      = iw_idx[SEL_W-1:0];
    assign in_range = ({1'b0, iw_idx} < NUM_CSR_V);
    // Flush cancels the request even while stalled.
    assign accept   = iw_valid & ~iw_stall & ~iw_flush;
    assign is_mod   = (op != OP_RD);

`ifdef CSR_CYCLE_EN
    localparam logic [SEL_W-1:0] LO_SEL = SEL_W'(NUM_CSR - 2);
    localparam logic [SEL_W-1:0] HI_SEL = SEL_W'(NUM_CSR - 1);

    logic [2*DATA_W-1:0] cycle_q;
    logic [DATA_W-1:0]   shadow_q;
`endif

    always_comb begin
        // NOTE: every signal gets a default before any branch so the block
        // stays purely combinational and no latch is inferred.
        old_val = csr_q[sel];
        ro      = RO_MASK[sel];
`ifdef CSR_CYCLE_EN
        if (sel == LO_SEL) begin
            old_val = cycle_q[DATA_W-1:0];
            ro      = 1'b1;
        end else if (sel == HI_SEL) begin
            old_val = shadow_q;
            ro      = 1'b1;
        end
`endif
        err_nxt   = ~in_range | (is_mod & ro);
        rdata_nxt = in_range ? old_val : '0;
        wr_en     = accept & in_range & is_mod & ~ro;

        unique case (op)
            OP_WR:   new_val = iw_wdata;
            OP_SET:  new_val = old_val | iw_wdata;
            OP_CLR:  new_val = old_val & ~iw_wdata;
            default: new_val = old_val;
        endcase
    end

    // The CSR update and the response share one edge, so a back-to-back
    // request to the same index naturally reads the updated value.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            // NOTE: the register array is reset element by element because
            // software expects every CSR to read 0 after reset; a plain RAM
            // would not allow this.
            for (int i = 0; i < NUM_CSR; i++) begin
                csr_q[i] <= '0;
            end
            ow_valid <= 1'b0;
            ow_rdata <= '0;
            ow_err   <= 1'b0;
        end else begin
            // NOTE: state is written with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (wr_en) begin
                csr_q[sel] <= new_val;
            end
            if (iw_flush) begin
                ow_valid <= 1'b0;
            end else if (!iw_stall) begin
                ow_valid <= iw_valid;
                if (iw_valid) begin
                    ow_rdata <= rdata_nxt;
                    ow_err   <= err_nxt;
                end
            end
        end
    end

`ifdef CSR_CYCLE_EN
    // Free-running counter: advances on stall and flush cycles too.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            cycle_q  <= '0;
            shadow_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (accept && in_range && (op == OP_RD) && (sel == LO_SEL)) begin
                shadow_q <= cycle_q[2*DATA_W-1:DATA_W];
            end
        end
    end
`endif

endmodule

// File: tb/tb_stg_csr_bank.sv
// ---------------------------------------------------------------------------
// tb_stg_csr_bank
//   Directed scenarios followed by randomized traffic for stg_csr_bank,
//   checked against a behavioural model of the CSR bank kept in this file.
//   The DUT is built with RO_MASK = 8'h02 so CSR 1 is read-only.
//   Defining CSR_CYCLE_EN also exercises the cycle-counter CSRs.
// ---------------------------------------------------------------------------
module tb_stg_csr_bank;

    localparam int          DATA_W  = 24;
    localparam int          NUM_CSR = 8;
    localparam int          IDX_W   = 4;
    localparam logic [7:0]  RO      = 8'h02;

    localparam logic [1:0] RD  = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] SET = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              valid;
    logic [1:0]        op;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
    logic              o_valid;
    logic [DATA_W-1:0] o_rdata;
    logic              o_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_csr [NUM_CSR];
    logic              m_valid;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;
    logic [47:0]       m_cyc;
    logic [DATA_W-1:0] m_shadow;
`ifdef CSR_CYCLE_EN
    localparam bit CYC = 1'b1;
`else
    localparam bit CYC = 1'b0;
`endif

    stg_csr_bank #(
        .DATA_W (DATA_W),
        .NUM_CSR(NUM_CSR),
        .IDX_W  (IDX_W),
        .RO_MASK(RO)
    ) dut (
        .iw_clk  (clk),
        .iw_rst  (rst),
        .iw_stall(stall),
        .iw_flush(flush),
        .iw_valid(valid),
        .iw_op   (op),
        .iw_idx  (idx),
        .iw_wdata(wdata),
        .ow_valid(o_valid),
        .ow_rdata(o_rdata),
        .ow_err  (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the architectural behaviour.
    task automatic model_edge(input logic r, input logic v, input logic [1:0] o,
                              input int i, input logic [DATA_W-1:0] wd,
                              input logic st, input logic fl);
        logic [DATA_W-1:0] old;
        bit ro_i;
        if (r) begin
            foreach (m_csr[k]) m_csr[k] = '0;
            m_valid = 0; m_rdata = '0; m_err = 0; m_cyc = '0; m_shadow = '0;
            return;
        end
        if (fl) begin
            m_valid = 0;
        end else if (!st) begin
            if (!v) begin
                m_valid = 0;
            end else begin
                m_valid = 1;
                if (i >= NUM_CSR) begin
                    m_err = 1; m_rdata = '0;
                end else begin
                    ro_i = RO[i] || (CYC && i >= NUM_CSR - 2);
                    if (CYC && i == NUM_CSR - 2)      old = m_cyc[23:0];
                    else if (CYC && i == NUM_CSR - 1) old = m_shadow;
                    else                              old = m_csr[i];
                    m_rdata = old;
                    if (o == RD) begin
                        m_err = 0;
                        if (CYC && i == NUM_CSR - 2) m_shadow = m_cyc[47:24];
                    end else if (ro_i) begin
                        m_err = 1;
                    end else begin
                        m_err = 0;
                        case (o)
                            WR:      m_csr[i] = wd;
                            SET:     m_csr[i] = old | wd;
                            default: m_csr[i] = old & ~wd;
                        endcase
                    end
                end
            end
        end
        if (CYC) m_cyc = m_cyc + 48'd1;
    endtask

    // Drive one cycle from a negedge, step the model at the posedge,
    // compare just after it, and return at the next negedge.
    task automatic step(input logic v, input logic [1:0] o, input int i,
                        input logic [DATA_W-1:0] wd, input logic st,
                        input logic fl, input logic r);
        valid = v; op = o; idx = IDX_W'(i); wdata = wd;
        stall = st; flush = fl; rst = r;
        @(posedge clk);
        model_edge(r, v, o, i, wd, st, fl);
        #1;
        check("valid", {47'd0, o_valid}, {47'd0, m_valid});
        check("rdata", {24'd0, o_rdata}, {24'd0, m_rdata});
        check("err",   {47'd0, o_err},   {47'd0, m_err});
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] o, input int i, input logic [DATA_W-1:0] wd);
        step(1'b1, o, i, wd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, RD, 0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, RD, 0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, RD, 0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; stall = 0; flush = 0; valid = 0; op = RD; idx = '0; wdata = '0;
        @(negedge clk);
        do_reset();
        check("reset_valid", {47'd0, o_valid}, 48'd0);
        check("reset_rdata", {24'd0, o_rdata}, 48'd0);
        check("reset_err",   {47'd0, o_err},   48'd0);

`ifdef CSR_CYCLE_EN
        // 10 counting edges, then RD LO on the 11th edge.
        for (int k = 0; k < 10; k++) idle();
        req(RD, NUM_CSR - 2, '0);
        check("cyc_lo", {24'd0, o_rdata}, 48'h00000A);
        req(RD, NUM_CSR - 1, '0);
        check("cyc_hi", {24'd0, o_rdata}, 48'h000000);
        dut.cycle_q = 48'h000000_FFFFFF;
        m_cyc       = 48'h000000_FFFFFF;
        req(RD, NUM_CSR - 2, '0);
        check("cyc_lo_wrap", {24'd0, o_rdata}, 48'hFFFFFF);
        req(RD, NUM_CSR - 1, '0);
        check("cyc_hi_shadow", {24'd0, o_rdata}, 48'h000000);
        check("cyc_hi_live", {24'd0, dut.cycle_q[47:24]}, 48'h000001);
        req(WR, NUM_CSR - 2, 24'h123456);
        check("cyc_ro_err", {47'd0, o_err}, 48'd1);
        do_reset();
`endif

        // 1. read after reset
        req(RD, 3, '0);
        check("t1_valid", {47'd0, o_valid}, 48'd1);
        check("t1_rdata", {24'd0, o_rdata}, 48'h0);
        check("t1_err",   {47'd0, o_err},   48'd0);

        // 2. write then back-to-back read
        req(WR, 2, 24'h00A5B6);
        check("t2_wr_rdata", {24'd0, o_rdata}, 48'h0);
        req(RD, 2, '0);
        check("t2_rd_rdata", {24'd0, o_rdata}, 48'h00A5B6);

        // 3. set / clear
        req(SET, 2, 24'h000F00);
        check("t3_set_rdata", {24'd0, o_rdata}, 48'h00A5B6);
        req(CLR, 2, 24'h0000B6);
        check("t3_clr_rdata", {24'd0, o_rdata}, 48'h00AFB6);
        req(RD, 2, '0);
        check("t3_final", {24'd0, o_rdata}, 48'h00AF00);
        req(SET, 2, 24'h000000);
        check("t3_set0_rdata", {24'd0, o_rdata}, 48'h00AF00);
        req(RD, 2, '0);
        check("t3_set0_keep", {24'd0, o_rdata}, 48'h00AF00);

        // 4. read-only and out-of-range
        req(WR, 1, 24'h123456);
        check("t4_ro_err",   {47'd0, o_err},   48'd1);
        check("t4_ro_rdata", {24'd0, o_rdata}, 48'h0);
        req(RD, 1, '0);
        check("t4_ro_rd",     {24'd0, o_rdata}, 48'h0);
        check("t4_ro_rd_err", {47'd0, o_err},   48'd0);
        req(WR, 12, 24'h777777);
        check("t4_oor_err",   {47'd0, o_err},   48'd1);
        check("t4_oor_rdata", {24'd0, o_rdata}, 48'h0);

        // 5. flush and stall
        step(1'b1, WR, 4, 24'h00C0DE, 1'b0, 1'b1, 1'b0);
        check("t5_flush_valid", {47'd0, o_valid}, 48'd0);
        req(RD, 4, '0);
        check("t5_flush_noupd", {24'd0, o_rdata}, 48'h0);
        idle();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, WR, 5, 24'h00BEEF, 1'b1, 1'b0, 1'b0);
            check("t5_stall_valid", {47'd0, o_valid}, 48'd0);
        end
        req(WR, 5, 24'h00BEEF);
        check("t5_release_valid", {47'd0, o_valid}, 48'd1);
        idle();
        check("t5_one_resp", {47'd0, o_valid}, 48'd0);
        step(1'b1, CLR, 5, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
        req(RD, 5, '0);
        check("t5_stallflush", {24'd0, o_rdata}, 48'h00BEEF);

        // reset mid-stream drops the pending response
        step(1'b1, WR, 2, 24'h111111, 1'b0, 1'b0, 1'b1);
        check("rst_mid_valid", {47'd0, o_valid}, 48'd0);
        req(RD, 2, '0);
        check("rst_mid_clear", {24'd0, o_rdata}, 48'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 11)),
                 ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
